// File: rtl/adder_arbiter_if.sv
// Request/response bus shared by NREQ requesters and one 64-bit adder.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives requests and consumes results.
interface adder_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [64*NREQ-1:0] req_a;
  logic [64*NREQ-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [63:0]        resp_sum;
  logic               resp_cout;
  logic [15:0]        op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_cout, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_cout, op_count
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 64-bit adder between NREQ requesters.
// A granted request is summed combinationally and captured into a one-deep
// result register that is held until the consumer accepts it.

module sixty_four_bit_adder (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic        i_c_in,
  output logic [63:0] o_sum,
  output logic        o_c_out
);
  assign {o_c_out, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {64'd0, i_c_in};
endmodule

module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic           clk,
  input logic           rst,
  adder_arbiter_if.slave bus
);
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [63:0]     r_sum;
  logic            r_cout;
  logic [15:0]     r_count;

  logic            w_anyValid;
  logic [IDW-1:0]  w_grantIdx;
  logic [IDW-1:0]  w_nextPtr;
  logic            w_accept;
  logic [NREQ-1:0] w_reqReady;
  logic            w_xfer;
  logic [63:0]     w_a;
  logic [63:0]     w_b;
  logic            w_cin;
  logic [63:0]     w_sum;
  logic            w_cout;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    int idx;
    w_anyValid = 1'b0;
    w_grantIdx = '0;
    idx        = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(r_ptr) + i) % NREQ;
      if (!w_anyValid && bus.req_valid[idx[IDW-1:0]]) begin
        w_anyValid = 1'b1;
        w_grantIdx = idx[IDW-1:0];
      end
    end
  end

  // Operand mux feeding the single shared adder from the granted requester.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == w_grantIdx) begin
        w_a   = bus.req_a[k*64 +: 64];
        w_b   = bus.req_b[k*64 +: 64];
        w_cin = bus.req_cin[k];
      end
    end
  end

  sixty_four_bit_adder u_adder (
    .i_a     (w_a),
    .i_b     (w_b),
    .i_c_in  (w_cin),
    .o_sum   (w_sum),
    .o_c_out (w_cout)
  );

  assign w_nextPtr = (int'(w_grantIdx) == NREQ - 1) ? '0 : w_grantIdx + IDW'(1);

  // Grant generation and next state; the result slot can take a new operation
  // when empty or when its current result is being consumed this cycle.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_reqReady  = '0;
    w_xfer      = 1'b0;
    w_accept    = !rst && ((r_state == IDLE) || bus.resp_ready);
    if (w_accept && w_anyValid) begin
      w_reqReady[w_grantIdx] = 1'b1;
      w_xfer                 = 1'b1;
    end
    case (r_state)
      IDLE:    if (w_xfer) w_nextState = HOLD;
      HOLD:    if (w_xfer) w_nextState = HOLD;
               else if (bus.resp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Result register and pointer, loaded only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_id   <= '0;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_id   <= w_grantIdx;
      r_ptr  <= w_nextPtr;
    end
  end

  // Saturating count of results handed to the consumer.
  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else if ((r_state == HOLD) && bus.resp_ready && (r_count != 16'hFFFF))
      r_count <= r_count + 16'd1;
  end

  assign bus.req_ready  = w_reqReady;
  assign bus.resp_valid = (r_state == HOLD);
  assign bus.resp_id    = r_id;
  assign bus.resp_sum   = r_sum;
  assign bus.resp_cout  = r_cout;
  assign bus.op_count   = r_count;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed and random stimulus for adder_arbiter with a reference model of
// the grant pointer, result slot and counter, plus a result scoreboard.
module tb_adder_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  adder_arbiter_if #(.NREQ(NREQ)) bus ();

  adder_arbiter #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic        cout;
    logic [63:0] sum;
  } resp_t;

  logic [63:0]     opA [NREQ];
  logic [63:0]     opB [NREQ];
  logic [NREQ-1:0] opCin;
  resp_t           scoreboard [$];
  int              checks = 0;
  int              errors = 0;
  bit              mHold  = 1'b0;
  int              mPtr   = 0;
  int              mCount = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic respReady);
    bus.req_valid  = valid;
    bus.resp_ready = respReady;
    bus.req_cin    = opCin;
    for (int k = 0; k < NREQ; k++) begin
      bus.req_a[k*64 +: 64] = opA[k];
      bus.req_b[k*64 +: 64] = opB[k];
    end
  endtask

  function automatic int rrPick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  // One clock: check grant mid-cycle against the model, then check outputs after the edge.
  task automatic runCycle();
    logic [NREQ-1:0] expReady;
    logic [64:0]     full;
    resp_t           e;
    resp_t           got;
    int              g;
    bit              xfer;
    bit              countIt;
    #4;
    g        = rrPick(bus.req_valid, mPtr);
    xfer     = !rst && (!mHold || bus.resp_ready) && (g >= 0);
    expReady = '0;
    if (xfer) expReady[g] = 1'b1;
    checkOutput("req_ready", {60'd0, bus.req_ready}, {60'd0, expReady});
    if (xfer) begin
      full   = {1'b0, opA[g]} + {1'b0, opB[g]} + {64'd0, opCin[g]};
      e.id   = g[1:0];
      e.cout = full[64];
      e.sum  = full[63:0];
      scoreboard.push_back(e);
    end
    countIt = !rst && mHold && bus.resp_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      mHold  = 1'b0;
      mPtr   = 0;
      mCount = 0;
      scoreboard.delete();
      checkOutput("rst_sum", bus.resp_sum, 64'd0);
      checkOutput("rst_cout", {63'd0, bus.resp_cout}, 64'd0);
      checkOutput("rst_id", {62'd0, bus.resp_id}, 64'd0);
    end else begin
      if (countIt && mCount < 65535) mCount++;
      if (xfer) begin
        mHold = 1'b1;
        mPtr  = (g + 1) % NREQ;
        got   = scoreboard.pop_front();
        checkOutput("resp_id", {62'd0, bus.resp_id}, {62'd0, got.id});
        checkOutput("resp_sum", bus.resp_sum, got.sum);
        checkOutput("resp_cout", {63'd0, bus.resp_cout}, {63'd0, got.cout});
      end else if (mHold && bus.resp_ready) begin
        mHold = 1'b0;
      end
    end
    checkOutput("resp_valid", {63'd0, bus.resp_valid}, {63'd0, mHold});
    checkOutput("op_count", {48'd0, bus.op_count}, 64'(mCount));
  endtask

  initial begin
    $display("[TB] start");
    for (int k = 0; k < NREQ; k++) begin
      opA[k] = 64'd0;
      opB[k] = 64'd0;
    end
    opCin = '0;

    // Reset with every requester asking: no grant may appear during reset.
    rst = 1'b1;
    applyStimulus(4'b1111, 1'b1);
    runCycle();
    runCycle();
    checkOutput("reset_valid", {63'd0, bus.resp_valid}, 64'd0);
    checkOutput("reset_count", {48'd0, bus.op_count}, 64'd0);
    rst = 1'b0;

    // Single operation with carry out.
    opA[2]   = 64'hFFFF_FFFF_FFFF_FFFF;
    opB[2]   = 64'd1;
    opCin[2] = 1'b0;
    applyStimulus(4'b0100, 1'b0);
    runCycle();
    checkOutput("single_valid", {63'd0, bus.resp_valid}, 64'd1);
    checkOutput("single_id", {62'd0, bus.resp_id}, 64'd2);
    checkOutput("single_sum", bus.resp_sum, 64'd0);
    checkOutput("single_cout", {63'd0, bus.resp_cout}, 64'd1);
    applyStimulus(4'b0000, 1'b1);
    runCycle();
    checkOutput("single_count", {48'd0, bus.op_count}, 64'd1);
    checkOutput("idle_keeps_sum", bus.resp_sum, 64'd0);

    // Pointer sits at 3; requesters 0 and 1 ask, so 0 wins then 1.
    opA[0] = 64'd100; opB[0] = 64'd23; opCin[0] = 1'b1;
    opA[1] = 64'h8000_0000_0000_0000; opB[1] = 64'h8000_0000_0000_0000; opCin[1] = 1'b1;
    applyStimulus(4'b0011, 1'b1);
    runCycle();
    checkOutput("wrap_id", {62'd0, bus.resp_id}, 64'd0);
    checkOutput("wrap_sum", bus.resp_sum, 64'd124);
    runCycle();
    checkOutput("wrap_next_id", {62'd0, bus.resp_id}, 64'd1);
    checkOutput("wrap_next_cout", {63'd0, bus.resp_cout}, 64'd1);

    // Reset while a result is held: it is dropped and not counted.
    rst = 1'b1;
    runCycle();
    checkOutput("midrst_valid", {63'd0, bus.resp_valid}, 64'd0);
    checkOutput("midrst_count", {48'd0, bus.op_count}, 64'd0);
    rst = 1'b0;

    // All requesters busy with consumer always ready: 0,1,2,3,0.
    for (int k = 0; k < NREQ; k++) begin
      opA[k]   = 64'd1000 * (k + 1);
      opB[k]   = 64'd7 + k;
      opCin[k] = k[0];
    end
    applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      runCycle();
      checkOutput("rr_id", {62'd0, bus.resp_id}, 64'(i % 4));
      checkOutput("rr_count", {48'd0, bus.op_count}, 64'(i));
    end
    applyStimulus(4'b0000, 1'b1);
    runCycle();

    // Backpressure: result held for three cycles, no new grants.
    opA[0] = 64'd5; opB[0] = 64'd7; opCin[0] = 1'b1;
    applyStimulus(4'b0001, 1'b0);
    runCycle();
    for (int i = 0; i < 3; i++) begin
      runCycle();
      checkOutput("bp_sum", bus.resp_sum, 64'd13);
      checkOutput("bp_count", {48'd0, bus.op_count}, 64'd5);
    end
    applyStimulus(4'b0000, 1'b1);
    runCycle();
    checkOutput("bp_release_count", {48'd0, bus.op_count}, 64'd6);

    // Random requests, withdrawals and consumer stalls.
    for (int i = 0; i < 80; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        opA[k]   = {$urandom, $urandom};
        opB[k]   = {$urandom, $urandom};
        opCin[k] = 1'($urandom_range(0, 1));
      end
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      runCycle();
    end

    // Counter saturation under continuous traffic.
    rst = 1'b1;
    runCycle();
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 65540; i++) runCycle();
    checkOutput("sat_count", {48'd0, bus.op_count}, 64'hFFFF);
    for (int i = 0; i < 3; i++) runCycle();
    checkOutput("sat_hold", {48'd0, bus.op_count}, 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing one sixty_four_bit_adder instance (legal 2..8).
REQ-002 Parameter: IDW, default $clog2(NREQ), requester-ID width.
REQ-003 Port: clk  input  1  sole clock, rising-edge.
REQ-004 Port: rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 Port: req_valid  input  NREQ  per-requester operation request.
REQ-006 Port: req_ready  output  NREQ  per-requester grant; one-hot or zero.
REQ-007 Port: req_a  input  64*NREQ  operand A, requester k in bits [64k+63:64k].
REQ-008 Port: req_b  input  64*NREQ  operand B, same packing.
REQ-009 Port: req_cin  input  NREQ  carry-in per requester.
REQ-010 Port: resp_valid  output  1  result held valid.
REQ-011 Port: resp_ready  input  1  consumer accepts result.
REQ-012 Port: resp_id  output  IDW  index of requester owning result.
REQ-013 Port: resp_sum  output  64  registered sum.
REQ-014 Port: resp_cout  output  1  registered carry-out.
REQ-015 Port: op_count  output  16  completed-response counter, saturating.

Function
REQ-016 Block SHALL instantiate exactly one sixty_four_bit_adder, fed by a combinational mux selecting the granted requester's {req_cin, req_a, req_b}.
REQ-017 States SHALL be IDLE (resp_valid=0) and HOLD (resp_valid=1).
REQ-018 Accept window SHALL be open when state==IDLE, or state==HOLD and resp_ready==1.
REQ-019 While accept window open and any req_valid set, exactly one req_ready bit SHALL assert combinationally in the same cycle; otherwise req_ready SHALL be all zero.
REQ-020 Grant SHALL be round-robin: search req_valid from pointer ptr upward, wrapping NREQ-1 -> 0; first set bit wins.
REQ-021 On a transfer (req_valid[g] & req_ready[g]), ptr SHALL become (g+1) mod NREQ at the next edge; ptr SHALL not change otherwise.
REQ-022 On a transfer, resp_sum, resp_cout, resp_id SHALL register adder sum, c_out, g at that edge; state -> HOLD; latency request-to-resp_valid = 1 cycle.
REQ-023 In HOLD with resp_ready==0, resp_* SHALL remain stable and req_ready SHALL be zero (backpressure).
REQ-024 In HOLD with resp_ready==1 and no req_valid, state SHALL go to IDLE; resp_sum/resp_cout/resp_id retain last values.
REQ-025 In HOLD with resp_ready==1 and a transfer, state SHALL stay HOLD with new result loaded (back-to-back, one op/cycle).
REQ-026 op_count SHALL increment on each resp_valid & resp_ready cycle, saturating at 16'hFFFF.
REQ-027 Sum SHALL be a+b+cin mod 2^64; cout SHALL be bit 64 of the 65-bit sum.
REQ-028 req_valid deasserted by a requester before grant SHALL be ignored; no requirement to hold it (design tolerates withdrawal).

Reset
REQ-029 When rst=1 at an edge: state=IDLE, resp_valid=0, resp_sum=0, resp_cout=0, resp_id=0, ptr=0, op_count=0.
REQ-030 During a cycle with rst=1, req_ready SHALL be all zero; an in-flight HOLD result SHALL be discarded without counting.

Verification
REQ-031 Single op: after reset, req_valid=4'b0100, a2=64'hFFFF_FFFF_FFFF_FFFF, b2=1, cin2=0 -> req_ready=4'b0100 same cycle; next cycle resp_valid=1, resp_id=2, resp_sum=0, resp_cout=1.
REQ-032 Round-robin: req_valid=4'b1111 held, resp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; op_count increments each cycle from cycle 2.
REQ-033 Backpressure: result a=5,b=7,cin=1 held with resp_ready=0 for 3 cycles -> resp_sum=13 stable, req_ready=0, op_count unchanged; on resp_ready=1 op_count +1.
REQ-034 Pointer wrap: ptr=3 (after granting 2), req_valid=4'b0011 -> grant 0, then ptr=1.
REQ-035 Reset mid-op: rst=1 while HOLD -> next cycle resp_valid=0, op_count=0, resp_sum=0; next grant from requester 0.
REQ-036 Saturation: 65536+ accepted responses -> op_count=16'hFFFF and holds.
